// File: rtl/prbs_ber_tester.sv
// prbs_ber_tester
//   PRBS source and self-synchronising PRBS checker for the link BER test.
//   The generator is a Fibonacci LFSR whose output bit drives the modulator.
//   The checker loads PRBS_W received bits and predicts every later bit from
//   its own predicted history. It verifies one window and then declares lock.
//   While locked it counts checked bits and errors. When one window holds too
//   many errors it drops back to LOAD and resynchronises.
//
// Ports
//   clk_signal  in          bit-rate clock, rising edge
//   rst         in          asynchronous reset, active high
//   clear       in          synchronous clear of bit_cnt/err_cnt/resync_cnt
//   tx_en       in          advance the generator by one bit
//   tx_bit      out         registered PRBS output bit
//   rx_valid    in          rx_bit carries a valid received sample
//   rx_bit      in          received bit from the demodulator
//   locked      out         checker is in LOCKED
//   err_pulse   out         one-cycle pulse for each error counted while locked
//   bit_cnt     out CNT_W   bits checked while locked, saturating
//   err_cnt     out CNT_W   errors while locked, saturating
//   resync_cnt  out RSY_W   LOCKED->LOAD transitions, saturating
module prbs_ber_tester #(
  parameter int unsigned       PRBS_W    = 7,
  parameter logic [PRBS_W-1:0] PRBS_TAPS = 7'b1100000,
  parameter logic [PRBS_W-1:0] SEED      = 7'b0000001,
  parameter int unsigned       WIN_LEN   = 64,
  parameter int unsigned       LOCK_THR  = 2,
  parameter int unsigned       LOSS_THR  = 8,
  parameter int unsigned       CNT_W     = 24,
  parameter int unsigned       RSY_W     = 8
) (
  input  logic             clk_signal,
  input  logic             rst,
  input  logic             clear,
  input  logic             tx_en,
  output logic             tx_bit,
  input  logic             rx_valid,
  input  logic             rx_bit,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [RSY_W-1:0] resync_cnt
);

  // An all-zero LFSR state never leaves zero, so a zero seed becomes 1.
  localparam logic [PRBS_W-1:0] SEED_EFF = (SEED == '0) ? PRBS_W'(1) : SEED;
  localparam int unsigned WC_W = $clog2(WIN_LEN + 1);
  localparam int unsigned LD_W = $clog2(PRBS_W + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_VERIFY, ST_LOCKED} state_t;

  // ---------------- generator ----------------
  logic [PRBS_W-1:0] gen_q;
  logic              tx_bit_q;
  logic              gen_fb;

  assign gen_fb = ^(gen_q & PRBS_TAPS);

  always_ff @(posedge clk_signal or posedge rst) begin
    if (rst) begin
      gen_q    <= SEED_EFF;
      tx_bit_q <= 1'b0;
    end else if (tx_en) begin
      gen_q    <= {gen_q[PRBS_W-2:0], gen_fb};
      tx_bit_q <= gen_fb;
    end
  end

  assign tx_bit = tx_bit_q;

  // ---------------- checker ----------------
  state_t            state_q, state_d;
  logic [PRBS_W-1:0] chk_q, chk_d;
  logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WC_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [RSY_W-1:0]  rsy_cnt_q, rsy_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              locked_q;

  logic              exp_bit;
  logic              mis;
  logic [WC_W-1:0]   win_err_inc;
  logic [PRBS_W-1:0] load_shift;
  logic [PRBS_W-1:0] pred_shift;

  assign exp_bit     = ^(chk_q & PRBS_TAPS);
  assign mis         = exp_bit ^ rx_bit;
  assign win_err_inc = win_err_q + WC_W'(mis);
  assign load_shift  = {chk_q[PRBS_W-2:0], rx_bit};
  // Once loaded, the history is fed with the predicted bit, so a received
  // error never corrupts later predictions.
  assign pred_shift  = {chk_q[PRBS_W-2:0], exp_bit};

  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    ld_cnt_d    = ld_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    rsy_cnt_d   = rsy_cnt_q;
    err_pulse_d = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        ST_LOAD: begin
          chk_d = load_shift;
          if (ld_cnt_q == LD_W'(PRBS_W - 1)) begin
            ld_cnt_d = '0;
            // An all-zero load cannot be predicted from, so load again.
            if (load_shift != '0) begin
              state_d   = ST_VERIFY;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end

        ST_VERIFY: begin
          chk_d     = pred_shift;
          win_err_d = win_err_inc;
          if (win_cnt_q == WC_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_inc <= WC_W'(LOCK_THR)) begin
              state_d = ST_LOCKED;
            end else begin
              state_d  = ST_LOAD;
              chk_d    = '0;
              ld_cnt_d = '0;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          chk_d       = pred_shift;
          err_pulse_d = mis;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
          if (mis && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
          if (win_err_inc >= WC_W'(LOSS_THR)) begin
            state_d   = ST_LOAD;
            chk_d     = '0;
            ld_cnt_d  = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            if (rsy_cnt_q != '1) rsy_cnt_d = rsy_cnt_q + 1'b1;
          end else if (win_cnt_q == WC_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end

    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      rsy_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_signal or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      chk_q       <= '0;
      ld_cnt_q    <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      rsy_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_q       <= chk_d;
      ld_cnt_q    <= ld_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rsy_cnt_q   <= rsy_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign bit_cnt    = bit_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign resync_cnt = rsy_cnt_q;

endmodule

// File: tb/tb_prbs_ber_tester.sv
// Bench for prbs_ber_tester: two instances (default counters and a 4-bit
// counter variant) share one stimulus and one behavioural model.
module tb_prbs_ber_tester;

  localparam int         W    = 7;
  localparam logic [6:0] TAPS = 7'b1100000;
  localparam logic [6:0] SEED = 7'b0000001;
  localparam int         WIN  = 64;
  localparam int         LTHR = 2;
  localparam int         LOSS = 8;

  localparam int M_LOAD = 0;
  localparam int M_VER  = 1;
  localparam int M_LOCK = 2;

  logic clk_signal = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic tx_en = 1'b0;
  logic rx_valid = 1'b0;
  logic rx_bit = 1'b0;

  logic        tx_bit, locked, err_pulse;
  logic [23:0] bit_cnt, err_cnt;
  logic [7:0]  resync_cnt;
  logic        tx_bit4, locked4, err_pulse4;
  logic [3:0]  bit_cnt4, err_cnt4;
  logic [7:0]  resync_cnt4;

  prbs_ber_tester dut (
    .clk_signal(clk_signal), .rst(rst), .clear(clear), .tx_en(tx_en),
    .tx_bit(tx_bit), .rx_valid(rx_valid), .rx_bit(rx_bit), .locked(locked),
    .err_pulse(err_pulse), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
    .resync_cnt(resync_cnt)
  );

  prbs_ber_tester #(.CNT_W(4)) dut4 (
    .clk_signal(clk_signal), .rst(rst), .clear(clear), .tx_en(tx_en),
    .tx_bit(tx_bit4), .rx_valid(rx_valid), .rx_bit(rx_bit), .locked(locked4),
    .err_pulse(err_pulse4), .bit_cnt(bit_cnt4), .err_cnt(err_cnt4),
    .resync_cnt(resync_cnt4)
  );

  always #5 clk_signal = ~clk_signal;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // vs: virtual seed history (oldest first) followed by every generated bit.
  // ph: bits the checker currently predicts from (loaded or predicted).
  bit     vs[$];
  bit     ph[$];
  int     ntx, nload, wcnt, werr, mode;
  longint bc[2], ec[2], rc[2];
  longint cmax[2];
  bit     m_tx, m_pulse;

  // Next bit of a sequence obeying s[n] = XOR over taps k of s[n-k-1].
  function automatic bit lfsr_next(input bit hist[$]);
    logic [6:0] t;
    bit r;
    t = TAPS;
    r = 1'b0;
    for (int k = 0; k < W; k++)
      if (t[k]) r ^= hist[hist.size() - 1 - k];
    return r;
  endfunction

  task automatic model_reset();
    logic [6:0] sd;
    sd = SEED;
    if (sd == 7'd0) sd = 7'd1;
    vs.delete();
    for (int k = W - 1; k >= 0; k--) vs.push_back(sd[k]);
    ph.delete();
    ntx = 0; nload = 0; wcnt = 0; werr = 0; mode = M_LOAD;
    m_tx = 1'b0; m_pulse = 1'b0;
    cmax[0] = (64'd1 << 24) - 1;
    cmax[1] = 15;
    for (int i = 0; i < 2; i++) begin
      bc[i] = 0; ec[i] = 0; rc[i] = 0;
    end
  endtask

  task automatic model_edge(input bit te, input bit rv, input bit rb, input bit cl);
    bit e, p, allz;
    if (te) begin
      p = lfsr_next(vs);
      vs.push_back(p);
      ntx++;
      m_tx = p;
    end
    m_pulse = 1'b0;
    if (rv) begin
      if (mode == M_LOAD) begin
        ph.push_back(rb);
        nload++;
        if (nload == W) begin
          allz = 1'b1;
          foreach (ph[i]) if (ph[i]) allz = 1'b0;
          nload = 0;
          if (allz) ph.delete();
          else begin mode = M_VER; wcnt = 0; werr = 0; end
        end
      end else begin
        p = lfsr_next(ph);
        e = p ^ rb;
        ph.push_back(p);
        if (ph.size() > W) void'(ph.pop_front());
        wcnt++;
        werr += int'(e);
        if (mode == M_VER) begin
          if (wcnt == WIN) begin
            if (werr <= LTHR) mode = M_LOCK;
            else begin mode = M_LOAD; ph.delete(); nload = 0; end
            wcnt = 0; werr = 0;
          end
        end else begin
          m_pulse = e;
          for (int i = 0; i < 2; i++) begin
            if (bc[i] < cmax[i]) bc[i]++;
            if (e && ec[i] < cmax[i]) ec[i]++;
          end
          if (werr >= LOSS) begin
            mode = M_LOAD; ph.delete(); nload = 0; wcnt = 0; werr = 0;
            for (int i = 0; i < 2; i++) if (rc[i] < 255) rc[i]++;
          end else if (wcnt == WIN) begin
            wcnt = 0; werr = 0;
          end
        end
      end
    end
    if (cl) begin
      for (int i = 0; i < 2; i++) begin
        bc[i] = 0; ec[i] = 0; rc[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("tx_bit", 64'(tx_bit), 64'(m_tx));
    chk("locked", 64'(locked), 64'(mode == M_LOCK));
    chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
    chk("bit_cnt", 64'(bit_cnt), bc[0]);
    chk("err_cnt", 64'(err_cnt), ec[0]);
    chk("resync_cnt", 64'(resync_cnt), rc[0]);
    chk("tx_bit4", 64'(tx_bit4), 64'(m_tx));
    chk("locked4", 64'(locked4), 64'(mode == M_LOCK));
    chk("err_pulse4", 64'(err_pulse4), 64'(m_pulse));
    chk("bit_cnt4", 64'(bit_cnt4), bc[1]);
    chk("err_cnt4", 64'(err_cnt4), ec[1]);
    chk("resync_cnt4", 64'(resync_cnt4), rc[1]);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_tx_bit"}, 64'(tx_bit), 64'd0);
    chk({name, "_locked"}, 64'(locked), 64'd0);
    chk({name, "_err_pulse"}, 64'(err_pulse), 64'd0);
    chk({name, "_bit_cnt"}, 64'(bit_cnt), 64'd0);
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({name, "_resync_cnt"}, 64'(resync_cnt), 64'd0);
    chk({name, "_locked4"}, 64'(locked4), 64'd0);
    chk({name, "_bit_cnt4"}, 64'(bit_cnt4), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int rx_ptr = 0;
  bit inv = 1'b0;
  bit force0 = 1'b0;

  // Drive at the falling edge, advance the model at the rising edge, and
  // compare at the next falling edge.
  task automatic step(input bit te, input bit rv, input bit flip, input bit cl);
    bit rb;
    if (rv && force0) rb = 1'b0;
    else if (rv) begin
      rb = vs[W + rx_ptr] ^ flip ^ inv;
      rx_ptr++;
    end else rb = 1'($urandom_range(0, 1));
    tx_en = te; rx_valid = rv; rx_bit = rb; clear = cl;
    @(posedge clk_signal);
    model_edge(te, rv, rb, cl);
    @(negedge clk_signal);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk_signal);
    @(negedge clk_signal);
    rst = 1'b0;
  endtask

  initial begin
    logic [13:0] txcap;
    int n, cyc, nv, burst;
    bit te, rv, fl, cl;

    model_reset();
    do_reset();
    chk_zero("reset");

    // Lock on a fixed 13-cycle link delay.
    txcap = '0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      txcap = {txcap[12:0], tx_bit};
    end
    chk("tx_first14", 64'(txcap), 64'(14'b00000110000101));
    rx_ptr = 1;
    n = 0;
    while (n < 200 && !locked) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("lock_latency", 64'(n), 64'd71);
    chk("err_cnt_at_lock", 64'(err_cnt), 64'd0);
    chk("bit_cnt_at_lock", 64'(bit_cnt), 64'd0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bit_cnt_20", 64'(bit_cnt), 64'd20);
    chk("bit_cnt4_sat", 64'(bit_cnt4), 64'd15);

    // Single flipped bit.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("single_err_pulse", 64'(err_pulse), 64'd1);
    chk("single_err_cnt", 64'(err_cnt), 64'd1);
    chk("single_locked", 64'(locked), 64'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("single_pulse_end", 64'(err_pulse), 64'd0);
    chk("single_bit_cnt", 64'(bit_cnt), 64'd22);

    // Eight errors at the start of a fresh window force a resync.
    n = 0;
    while (n < 70 && wcnt != 0) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 6) chk("loss_locked_after7", 64'(locked), 64'd1);
    end
    chk("loss_locked_after8", 64'(locked), 64'd0);
    chk("loss_resync_cnt", 64'(resync_cnt), 64'd1);
    chk("loss_err_cnt", 64'(err_cnt), 64'd9);
    n = 0;
    while (n < 200 && !locked) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("relock_latency", 64'(n), 64'd71);

    // Clear beats the same-cycle increment and leaves the lock alone.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_bit_cnt", 64'(bit_cnt), 64'd0);
    chk("clear_resync_cnt", 64'(resync_cnt), 64'd0);
    chk("clear_bit_cnt4", 64'(bit_cnt4), 64'd0);
    chk("clear_locked", 64'(locked), 64'd1);

    // Constant-zero input never leaves LOAD.
    do_reset();
    force0 = 1'b1;
    repeat (200) step(1'b0, 1'b1, 1'b0, 1'b0);
    force0 = 1'b0;
    chk_zero("zero_input");

    // Asynchronous reset while verifying.
    do_reset();
    rx_ptr = 0;
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (17) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_verify_model_mode", 64'(mode), 64'(M_VER));
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk_signal);
    rst = 1'b0;

    // rx_valid one cycle in three.
    rx_ptr = 0;
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    cyc = 0; nv = 0;
    while (cyc < 400 && !locked) begin
      rv = (cyc % 3 == 2);
      step(1'b1, rv, 1'b0, 1'b0);
      cyc++;
      if (rv) nv++;
    end
    chk("sparse_lock_cycles", 64'(cyc), 64'd213);
    chk("sparse_lock_valid", 64'(nv), 64'd71);
    repeat (30) begin
      step(1'b1, (cyc % 3 == 2), 1'b0, 1'b0);
      cyc++;
    end
    chk("sparse_bit_cnt", 64'(bit_cnt), 64'd10);

    // Randomised traffic: gaps on both sides, sparse errors, bursts, clears.
    do_reset();
    rx_ptr = 0;
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    burst = 0;
    for (int i = 0; i < 2500; i++) begin
      te = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 3) != 0) && (rx_ptr < ntx);
      if ($urandom_range(0, 599) == 0) burst = 12;
      fl = rv && (burst > 0 || $urandom_range(0, 149) == 0);
      if (rv && burst > 0) burst--;
      cl = ($urandom_range(0, 399) == 0);
      step(te, rv, fl, cl);
    end

    // Inverted link never locks.
    do_reset();
    rx_ptr = 0;
    inv = 1'b1;
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (400) step(1'b1, 1'b1, 1'b0, 1'b0);
    inv = 1'b0;
    chk("inverted_locked", 64'(locked), 64'd0);
    chk("inverted_resync", 64'(resync_cnt), 64'd0);
    chk("inverted_bit_cnt", 64'(bit_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
